// File: rtl/io_timer_slave.sv
// io_timer_slave: IO-bus mapped prescaled 32-bit interval timer with snapshot and level interrupt
module io_timer_slave #(
  parameter logic [15:0] BASE_ADDR = 16'h0100,
  parameter logic [15:0] ID_VALUE  = 16'h7391
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] io_address,
  input  logic        io_bus_enable,
  input  logic [1:0]  io_byte_enable,
  input  logic        io_rw,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        io_acknowledge,
  output logic        io_irq
);
  typedef enum logic [1:0] {IDLE, ACK, DONE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        to_q, to_d, irq_q;
  logic [15:0] pre_q, pre_d, pc_q, pc_d, rdata_q, rdata_d, rmux;
  logic [31:0] per_q, per_d, snap_q, snap_d, cnt_q, cnt_d;
  logic        sel, acc, wr, wr_lo, tick, expire;
  logic [2:0]  off;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] be, input logic [15:0] wd);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction

  assign sel    = io_bus_enable & ((io_address & 16'hFFF0) == (BASE_ADDR & 16'hFFF0));
  assign acc    = sel & (state_q == IDLE);
  assign wr     = acc & ~io_rw;
  assign wr_lo  = wr & io_byte_enable[0];
  assign off    = io_address[3:1];
  assign tick   = ctrl_q[0] & (pc_q == pre_q);
  assign expire = tick & (cnt_q == 32'd0);

  always_comb begin
    case (off)
      3'd0:    rmux = {13'd0, ctrl_q};
      3'd1:    rmux = {14'd0, ctrl_q[0], to_q};
      3'd2:    rmux = pre_q;
      3'd3:    rmux = per_q[15:0];
      3'd4:    rmux = per_q[31:16];
      3'd5:    rmux = snap_q[15:0];
      3'd6:    rmux = snap_q[31:16];
      default: rmux = ID_VALUE;
    endcase
  end

  always_comb begin
    state_d   = state_q == IDLE ? (sel ? ACK : IDLE) : state_q == ACK ? DONE : (io_bus_enable ? DONE : IDLE);
    ctrl_d    = ctrl_q;
    ctrl_d[0] = ctrl_q[0] & ~(expire & ~ctrl_q[1]);
    pc_d      = ctrl_q[0] ? (tick ? 16'd0 : pc_q + 16'd1) : pc_q;
    cnt_d     = !tick ? cnt_q : cnt_q != 32'd0 ? cnt_q - 32'd1 : ctrl_q[1] ? per_q : 32'd0;
    to_d      = expire | (to_q & ~(wr_lo & (off == 3'd1) & io_write_data[0]));
    pre_d     = (wr && off == 3'd2) ? merge(pre_q, io_byte_enable, io_write_data) : pre_q;
    per_d     = {(wr && off == 3'd4) ? merge(per_q[31:16], io_byte_enable, io_write_data) : per_q[31:16],
                 (wr && off == 3'd3) ? merge(per_q[15:0], io_byte_enable, io_write_data) : per_q[15:0]};
    snap_d    = (wr_lo && off == 3'd5) ? cnt_q : snap_q;
    // a CTRL write overrides the timer: EN=0 freezes, a 0->1 edge (incl. a same-edge one-shot expiry) reloads
    if (wr_lo && off == 3'd0) begin
      if (!io_write_data[0]) begin
        cnt_d = cnt_q;
        pc_d  = pc_q;
      end else if (!ctrl_d[0]) begin
        cnt_d = per_q;
        pc_d  = 16'd0;
      end
      ctrl_d = io_write_data[2:0];
    end
    rdata_d = (acc & io_rw) ? rmux : 16'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ctrl_q  <= 3'd0;
      to_q    <= 1'b0;
      irq_q   <= 1'b0;
      pre_q   <= 16'd0;
      pc_q    <= 16'd0;
      rdata_q <= 16'd0;
      per_q   <= 32'd0;
      snap_q  <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      to_q    <= to_d;
      irq_q   <= to_q & ctrl_q[2];
      pre_q   <= pre_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      per_q   <= per_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io_acknowledge = state_q == ACK;
  assign io_read_data   = rdata_q;
  assign io_irq         = irq_q;
endmodule
